uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx between N_REQ byte requesters via round-robin arbitration.

---
 rtl/uart_tx_arbiter_if.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 133 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte requesters, the uart_tx arbiter and uart_tx.
// The master side is the client/uart environment; the slave side is the arbiter.
interface uart_tx_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    localparam int IDW = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_lock;
    logic [N_REQ-1:0]        req_ready;
    logic [DATA_W-1:0]       tx_data;
    logic                    tx_valid;
    logic                    tx_ready;
    logic [IDW-1:0]          grant_id;
    logic                    locked;
    logic                    busy;

    modport master (
        output req_valid, req_data, req_lock, tx_ready,
        input  req_ready, tx_data, tx_valid, grant_id, locked, busy
    );

    modport slave (
        input  req_valid, req_data, req_lock, tx_ready,
        output req_ready, tx_data, tx_valid, grant_id, locked, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between N_REQ byte requesters.
// A granted byte is presented to uart_tx, the frame is waited out, and only
// then is the next grant made. An owner may lock the grant across a packet;
// the lock ends when the owner drops req_lock or stays idle for LOCK_TO cycles.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = 8,
    parameter int LOCK_TO = 1024
) (
    input logic                clk,
    input logic                rst,
    uart_tx_arbiter_if.slave   bus
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = $clog2(LOCK_TO + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] BUSY = 2'd2;

    logic [1:0]        state_r;
    logic [DATA_W-1:0] tx_data_r;
    logic              tx_valid_r;
    logic [IDW-1:0]    grant_id_r;
    logic [IDW-1:0]    ptr_r;
    logic              locked_r;
    logic [CW-1:0]     cnt_r;

    logic [N_REQ-1:0]  cand_s;
    logic [IDW-1:0]    idx_s;
    logic [IDW-1:0]    winner_s;
    logic              found_s;
    logic              lock_rel_s;
    logic              grant_s;
    logic [N_REQ-1:0]  ready_s;

    // Candidate set and first candidate at or after the round-robin pointer.
    always_comb begin
        cand_s   = '0;
        idx_s    = '0;
        winner_s = '0;
        found_s  = 1'b0;
        if (locked_r) begin
            cand_s[grant_id_r] = bus.req_valid[grant_id_r];
        end else begin
            cand_s = bus.req_valid;
        end
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = IDW'((int'(ptr_r) + k) % N_REQ);
            if (!found_s && cand_s[idx_s]) begin
                found_s  = 1'b1;
                winner_s = idx_s;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // A locked owner that dropped req_lock in IDLE gives up the lock instead of being granted.
    assign lock_rel_s = locked_r && !bus.req_lock[grant_id_r];
    assign grant_s    = (state_r == IDLE) && bus.tx_ready && found_s && !lock_rel_s;

    // One-hot ready to the winner; forced low while reset is asserted.
    always_comb begin
        ready_s = '0;
        if (grant_s && rst) begin
            ready_s[winner_s] = 1'b1;
        end else begin
            ready_s = '0;
        end
    end

    // Main FSM: grant in IDLE, present byte in SEND, wait for frame end in BUSY.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            tx_data_r  <= '0;
            tx_valid_r <= 1'b0;
            grant_id_r <= '0;
            ptr_r      <= '0;
            locked_r   <= 1'b0;
            cnt_r      <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        tx_data_r  <= bus.req_data[int'(winner_s)*DATA_W +: DATA_W];
                        tx_valid_r <= 1'b1;
                        grant_id_r <= winner_s;
                        ptr_r      <= (winner_s == IDW'(N_REQ - 1)) ? '0 : winner_s + 1'b1;
                        locked_r   <= bus.req_lock[winner_s];
                        cnt_r      <= '0;
                        state_r    <= SEND;
                    end else if (lock_rel_s) begin
                        locked_r <= 1'b0;
                        cnt_r    <= '0;
                    end else if (locked_r && !bus.req_valid[grant_id_r]) begin
                        // Idle timeout for a locked owner; the counter never wraps.
                        if (cnt_r == CW'(LOCK_TO - 1)) begin
                            locked_r <= 1'b0;
                            cnt_r    <= '0;
                        end else if (cnt_r != {CW{1'b1}}) begin
                            cnt_r <= cnt_r + 1'b1;
                        end
                    end
                end
                SEND: begin
                    // uart_tx dropping tx_ready means it captured the byte.
                    if (!bus.tx_ready) begin
                        tx_valid_r <= 1'b0;
                        state_r    <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.tx_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    tx_valid_r <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_s;
    assign bus.tx_data   = tx_data_r;
    assign bus.tx_valid  = tx_valid_r;
    assign bus.grant_id  = grant_id_r;
    assign bus.locked    = locked_r;
    assign bus.busy      = (state_r != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small uart_tx stand-in that
// captures each byte and stays not-ready for a few cycles per frame.
module tb_uart_tx_arbiter;
    localparam int N_REQ   = 4;
    localparam int DATA_W  = 8;
    localparam int LOCK_TO = 16;
    localparam int FRAME   = 4;

    logic clk;
    logic rst;
    logic force_low;
    int   ucnt;
    logic [7:0] cap_q[$];
    int   tests;
    int   fails;

    uart_tx_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .LOCK_TO(LOCK_TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.tx_ready = !force_low && (ucnt == 0);

    // uart_tx stand-in: take a byte on valid&ready, then be busy for FRAME cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ucnt <= 0;
        end else if (bus.tx_valid && bus.tx_ready) begin
            cap_q.push_back(bus.tx_data);
            ucnt <= FRAME;
        end else if (ucnt != 0) begin
            ucnt <= ucnt - 1;
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_data  = '0;
        force_low = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cap_q.delete();
        rst = 1'b1;
    endtask

    // Waits (bounded) for a non-zero req_ready; returns at negedge+1.
    task automatic wait_ready(output bit got);
        got = 1'b0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (|bus.req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Waits (bounded) for the FSM to come back to IDLE; returns at a negedge.
    task automatic wait_idle(output bit got);
        got = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!bus.busy) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bus.req_valid = 4'b1111;
        bus.req_lock  = 4'b0000;
        bus.req_data  = 32'hA3A2A1A0;
        force_low = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_tx: tx_valid=%b tx_data=%h busy=%b, required 0 00 0", bus.tx_valid, bus.tx_data, bus.busy);
        end
        tests++;
        if (bus.grant_id !== 2'd0 || bus.locked !== 1'b0) begin
            fails++;
            $display("FAIL reset_grant: grant_id=%0d locked=%b, required 0 0", bus.grant_id, bus.locked);
        end
        tests++;
        if (bus.req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_ready: req_ready=%b, required 0000", bus.req_ready);
        end
        do_reset();
    endtask

    task automatic test_single();
        bit got;
        do_reset();
        bus.req_data[7:0] = 8'h55;
        bus.req_valid = 4'b0001;
        wait_ready(got);
        tests++;
        if (!got || bus.req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL single_ready: req_ready=%b got=%b, required 0001", bus.req_ready, got);
        end
        @(negedge clk);
        tests++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h55 || bus.grant_id !== 2'd0) begin
            fails++;
            $display("FAIL single_tx: tx_valid=%b tx_data=%h grant_id=%0d, required 1 55 0", bus.tx_valid, bus.tx_data, bus.grant_id);
        end
        tests++;
        if (bus.req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL single_ready_pulse: req_ready=%b, required 0000", bus.req_ready);
        end
        bus.req_valid = 4'b0000;
        wait_idle(got);
        tests++;
        if (!got || cap_q.size() != 1 || cap_q[0] !== 8'h55) begin
            fails++;
            $display("FAIL single_uart: got=%b count=%0d, required one byte 55", got, cap_q.size());
        end
    endtask

    task automatic test_round_robin();
        bit got;
        logic [7:0] exp_b;
        logic [1:0] exp_id;
        do_reset();
        bus.req_data  = 32'hA3A2A1A0;
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            exp_id = 2'(k % 4);
            exp_b  = 8'hA0 + 8'(k % 4);
            wait_ready(got);
            tests++;
            if (!got || bus.req_ready !== (4'b0001 << exp_id)) begin
                fails++;
                $display("FAIL rr_ready[%0d]: req_ready=%b, required one-hot %0d", k, bus.req_ready, exp_id);
            end
            @(negedge clk);
            tests++;
            if (bus.grant_id !== exp_id || bus.tx_data !== exp_b) begin
                fails++;
                $display("FAIL rr_tx[%0d]: grant_id=%0d tx_data=%h, required %0d %h", k, bus.grant_id, bus.tx_data, exp_id, exp_b);
            end
        end
        bus.req_valid = 4'b0000;
        wait_idle(got);
        tests++;
        if (!got || cap_q.size() != 5 || cap_q[0] !== 8'hA0 || cap_q[1] !== 8'hA1 ||
            cap_q[2] !== 8'hA2 || cap_q[3] !== 8'hA3 || cap_q[4] !== 8'hA0) begin
            fails++;
            $display("FAIL rr_order: count=%0d, required A0 A1 A2 A3 A0", cap_q.size());
        end
    endtask

    task automatic test_lock();
        bit got;
        do_reset();
        bus.req_data[23:16] = 8'h10;
        bus.req_data[31:24] = 8'h30;
        bus.req_lock  = 4'b0100;
        bus.req_valid = 4'b1100;
        for (int k = 0; k < 3; k++) begin
            wait_ready(got);
            tests++;
            if (!got || bus.req_ready !== 4'b0100) begin
                fails++;
                $display("FAIL lock_ready[%0d]: req_ready=%b, required 0100", k, bus.req_ready);
            end
            @(negedge clk);
            tests++;
            if (bus.tx_data !== (8'h10 + 8'(k)) || bus.locked !== 1'b1 || bus.grant_id !== 2'd2) begin
                fails++;
                $display("FAIL lock_tx[%0d]: tx_data=%h locked=%b grant_id=%0d, required %h 1 2", k, bus.tx_data, bus.locked, bus.grant_id, 8'h10 + 8'(k));
            end
            if (k < 2) begin
                bus.req_data[23:16] = 8'h11 + 8'(k);
            end else begin
                bus.req_valid[2] = 1'b0;
                bus.req_lock[2]  = 1'b0;
            end
        end
        wait_ready(got);
        tests++;
        if (!got || bus.req_ready !== 4'b1000 || bus.locked !== 1'b0) begin
            fails++;
            $display("FAIL lock_release: req_ready=%b locked=%b, required 1000 0", bus.req_ready, bus.locked);
        end
        @(negedge clk);
        bus.req_valid = 4'b0000;
        tests++;
        if (bus.tx_data !== 8'h30 || bus.locked !== 1'b0) begin
            fails++;
            $display("FAIL lock_next: tx_data=%h locked=%b, required 30 0", bus.tx_data, bus.locked);
        end
        wait_idle(got);
    endtask

    task automatic test_timeout();
        bit got;
        bit early;
        int n;
        do_reset();
        bus.req_data[15:8] = 8'h77;
        bus.req_data[7:0]  = 8'h05;
        bus.req_lock  = 4'b0010;
        bus.req_valid = 4'b0010;
        wait_ready(got);
        @(negedge clk);
        bus.req_valid = 4'b0001;
        tests++;
        if (!got || bus.locked !== 1'b1 || bus.grant_id !== 2'd1) begin
            fails++;
            $display("FAIL to_lock: locked=%b grant_id=%0d got=%b, required 1 1", bus.locked, bus.grant_id, got);
        end
        wait_idle(got);
        n = 0;
        early = 1'b0;
        while (bus.locked && n < 100) begin
            if (|bus.req_ready) early = 1'b1;
            n++;
            @(negedge clk);
        end
        tests++;
        if (!got || n != LOCK_TO || early) begin
            fails++;
            $display("FAIL to_cycles: locked idle cycles=%0d early_grant=%b, required %0d 0", n, early, LOCK_TO);
        end
        #1;
        tests++;
        if (bus.req_ready !== 4'b0001) begin
            fails++;
            $display("FAIL to_grant: req_ready=%b, required 0001", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 4'b0000;
        bus.req_lock  = 4'b0000;
        wait_idle(got);
    endtask

    task automatic test_reset_mid();
        bit got;
        do_reset();
        bus.req_data[7:0] = 8'h3C;
        bus.req_valid = 4'b0001;
        wait_ready(got);
        @(negedge clk);
        tests++;
        if (!got || bus.tx_valid !== 1'b1) begin
            fails++;
            $display("FAIL mid_send: tx_valid=%b got=%b, required 1", bus.tx_valid, got);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (bus.tx_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL mid_abort: tx_valid=%b busy=%b req_ready=%b, required 0 0 0000", bus.tx_valid, bus.busy, bus.req_ready);
        end
        @(negedge clk);
        rst = 1'b1;
        wait_ready(got);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        wait_idle(got);
        tests++;
        if (!got || cap_q.size() != 1 || cap_q[0] !== 8'h3C) begin
            fails++;
            $display("FAIL mid_resend: count=%0d got=%b, required one byte 3C", cap_q.size(), got);
        end
    endtask

    task automatic test_tx_ready_block();
        bit got;
        bit seen;
        do_reset();
        force_low = 1'b1;
        bus.req_data[15:8] = 8'h99;
        bus.req_valid = 4'b0010;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            if (|bus.req_ready) seen = 1'b1;
        end
        tests++;
        if (seen) begin
            fails++;
            $display("FAIL block_hold: req_ready seen while tx_ready=0, required none");
        end
        force_low = 1'b0;
        #1;
        tests++;
        if (bus.req_ready !== 4'b0010) begin
            fails++;
            $display("FAIL block_release: req_ready=%b, required 0010", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 4'b0000;
        wait_idle(got);
        tests++;
        if (!got || cap_q.size() != 1 || cap_q[0] !== 8'h99) begin
            fails++;
            $display("FAIL block_uart: count=%0d got=%b, required one byte 99", cap_q.size(), got);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b0;
        force_low = 1'b0;
        bus.req_valid = '0;
        bus.req_lock  = '0;
        bus.req_data  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_timeout();
        test_reset_mid();
        test_tx_ready_block();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
